ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus execute-stage operand selection for the 5-stage RV32I pipeline.
- Captures decoded operands and control from Decode each cycle.
- Resolves RAW hazards by forwarding from the Memory and Writeback stages.
- Drives alu_opE, SrcAE and SrcBE straight into the ALU, and signals load-use stalls to the hazard logic.

Parameters:
XLEN, 32, datapath width
REGW, 5, register index width
ALUOPW, 5, ALU opcode width (00000 = add)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
StallE  input  1  hold all E-stage registers
FlushE  input  1  replace E-stage contents with a bubble
RD1D  input  XLEN  register file port 1 data
RD2D  input  XLEN  register file port 2 data
PCD  input  XLEN  PC of Decode instruction
ImmExtD  input  XLEN  sign-extended immediate
Rs1D  input  REGW  source 1 index
Rs2D  input  REGW  source 2 index
RdD  input  REGW  destination index
alu_opD  input  ALUOPW  ALU opcode
ALUSrcAD  input  1  0: rs1 operand, 1: PC (auipc/jal)
ALUSrcBD  input  1  0: rs2 operand, 1: immediate
RegWriteD  input  1  instruction writes rd
MemWriteD  input  1  store
ResultSrcD  input  2  00 ALU, 01 load, 10 PC+4
ALUResultM  input  XLEN  Memory-stage ALU result
RdM  input  REGW  Memory-stage rd
RegWriteM  input  1  Memory-stage write enable
ResultW  input  XLEN  Writeback result
RdW  input  REGW  Writeback rd
RegWriteW  input  1  Writeback write enable
alu_opE  output  ALUOPW  registered opcode to ALU
SrcAE  output  XLEN  ALU operand A
SrcBE  output  XLEN  ALU operand B
WriteDataE  output  XLEN  forwarded rs2 for stores
PCE  output  XLEN  registered PC
RdE  output  REGW  registered rd
RegWriteE  output  1  registered control
MemWriteE  output  1  registered control
ResultSrcE  output  2  registered control
ForwardAE  output  2  operand A forward select (debug/perf)
ForwardBE  output  2  operand B forward select
lwStall  output  1  load-use hazard detected

Behaviour:
- Register update priority per rising clk: rst > FlushE > StallE > load.
- Load: every D input is captured into its E register, including internal Rs1E and Rs2E.
- rst or FlushE: every E register is cleared to 0. This gives alu_opE=00000, RegWriteE=0, MemWriteE=0, ResultSrcE=00, RdE=0, PCE=0, and zero data/immediate. A bubble is therefore a harmless add of 0+0 to x0.
- StallE with no flush/rst: all E registers hold their value.
- Forward selects are combinational from E registers and M/W inputs:
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise ForwardAE=00.
  - ForwardBE uses the same rules with Rs2E.
  - M has priority over W. x0 is never forwarded.
- Forwarded operand values:
  - fwdA/fwdB = RD1E/RD2E for select 00, ResultW for 01, ALUResultM for 10.
  - Select 11 is unreachable and falls back to RD1E/RD2E.
- Operand muxing:
  - SrcAE = ALUSrcAE ? PCE : fwdA.
  - SrcBE = ALUSrcBE ? ImmExtE : fwdB.
  - WriteDataE = fwdB regardless of ALUSrcBE.
- lwStall (combinational) = (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D). External hazard logic stalls F/D and asserts FlushE in response; this block does not self-flush.
- Latency:
  - D to E registers: 1 cycle.
  - SrcAE, SrcBE, WriteDataE, ForwardAE, ForwardBE, lwStall: combinational in the same cycle.
- After reset with M/W idle (RegWriteM=RegWriteW=0): SrcAE=SrcBE=WriteDataE=0 and ForwardAE=ForwardBE=00.
- Reset or flush asserted mid-stall clears the registers; the stall does not preserve contents.
- No arithmetic is performed here; all widths pass through unchanged.

Test Plan:
- Reset/bubble: load RD1D=5, RD2D=7, alu_opD=00001, RegWriteD=1, RdD=3; assert rst for one cycle -> next cycle every E output=0, lwStall=0.
- Forward priority: Rs1E=4; RdM=4, RegWriteM=1, ALUResultM=0x10; RdW=4, RegWriteW=1, ResultW=0x20 -> ForwardAE=10, SrcAE=0x10. Then drop RegWriteM -> ForwardAE=01, SrcAE=0x20.
- x0 guard: Rs2E=0, RdM=0, RegWriteM=1, ALUResultM=0xFF, RD2E=0 -> ForwardBE=00, WriteDataE=0.
- Immediate/PC select: ALUSrcAD=1, PCD=0x100, ALUSrcBD=1, ImmExtD=0x8, and a forwardable Rs2 match -> SrcAE=0x100, SrcBE=0x8, WriteDataE=forwarded value.
- Stall vs flush: load instruction A, assert StallE for 2 cycles while D changes -> E outputs stay A. Assert StallE and FlushE together -> bubble (all zero).
- Load-use: E holds ResultSrcE=01, RdE=6; Rs2D=6 -> lwStall=1. Same case with RdE=0 -> lwStall=0.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with execute-stage forwarding and operand selection.
// Also flags load-use hazards for the external hazard unit.
module ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REGW   = 5,
  parameter int ALUOPW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [REGW-1:0]   Rs1D,
  input  logic [REGW-1:0]   Rs2D,
  input  logic [REGW-1:0]   RdD,
  input  logic [ALUOPW-1:0] alu_opD,
  input  logic              ALUSrcAD,
  input  logic              ALUSrcBD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [REGW-1:0]   RdM,
  input  logic              RegWriteM,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [REGW-1:0]   RdW,
  input  logic              RegWriteW,
  output logic [ALUOPW-1:0] alu_opE,
  output logic [XLEN-1:0]   SrcAE,
  output logic [XLEN-1:0]   SrcBE,
  output logic [XLEN-1:0]   WriteDataE,
  output logic [XLEN-1:0]   PCE,
  output logic [REGW-1:0]   RdE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic [1:0]        ResultSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              lwStall
);

  typedef struct packed {
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [REGW-1:0]   rs1;
    logic [REGW-1:0]   rs2;
    logic [REGW-1:0]   rd;
    logic [ALUOPW-1:0] alu_op;
    logic              alu_src_a;
    logic              alu_src_b;
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
  } e_regs_t;

  e_regs_t e_d, e_q;
  logic [XLEN-1:0] fwd_a, fwd_b;

  // An all-zero bubble decodes as add x0 = 0 + 0 with no side effects.
  always_comb begin
    e_d = e_q;
    if (FlushE) begin
      e_d = '0;
    end else if (!StallE) begin
      e_d.rd1        = RD1D;
      e_d.rd2        = RD2D;
      e_d.pc         = PCD;
      e_d.imm        = ImmExtD;
      e_d.rs1        = Rs1D;
      e_d.rs2        = Rs2D;
      e_d.rd         = RdD;
      e_d.alu_op     = alu_opD;
      e_d.alu_src_a  = ALUSrcAD;
      e_d.alu_src_b  = ALUSrcBD;
      e_d.reg_write  = RegWriteD;
      e_d.mem_write  = MemWriteD;
      e_d.result_src = ResultSrcD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) e_q <= '0;
    else     e_q <= e_d;
  end

  // Memory stage holds the younger result, so it wins over Writeback.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == e_q.rs1))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == e_q.rs1)) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == e_q.rs2))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == e_q.rs2)) ForwardBE = 2'b01;
  end

  always_comb begin
    case (ForwardAE)
      2'b01:   fwd_a = ResultW;
      2'b10:   fwd_a = ALUResultM;
      default: fwd_a = e_q.rd1;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = e_q.rd2;
    endcase
  end

  assign SrcAE      = e_q.alu_src_a ? e_q.pc  : fwd_a;
  assign SrcBE      = e_q.alu_src_b ? e_q.imm : fwd_b;
  assign WriteDataE = fwd_b;

  assign lwStall = (e_q.result_src == 2'b01) && (e_q.rd != '0) &&
                   ((e_q.rd == Rs1D) || (e_q.rd == Rs2D));

  assign alu_opE    = e_q.alu_op;
  assign PCE        = e_q.pc;
  assign RdE        = e_q.rd;
  assign RegWriteE  = e_q.reg_write;
  assign MemWriteE  = e_q.mem_write;
  assign ResultSrcE = e_q.result_src;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of the execute-stage contents.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, StallE, FlushE;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, ALUResultM, ResultW;
  logic [4:0]  Rs1D, Rs2D, RdD, RdM, RdW, alu_opD;
  logic        ALUSrcAD, ALUSrcBD, RegWriteD, MemWriteD, RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcD;

  logic [4:0]  alu_opE, RdE;
  logic [31:0] SrcAE, SrcBE, WriteDataE, PCE;
  logic        RegWriteE, MemWriteE, lwStall;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .alu_opD(alu_opD),
    .ALUSrcAD(ALUSrcAD), .ALUSrcBD(ALUSrcBD), .RegWriteD(RegWriteD),
    .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .alu_opE(alu_opE), .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
    .PCE(PCE), .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .lwStall(lwStall)
  );

  // Model of what the E stage currently holds.
  logic [31:0] m_rd1, m_rd2, m_pc, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd, m_op;
  logic        m_sa, m_sb, m_rw, m_mw;
  logic [1:0]  m_rsrc;

  always @(posedge clk) begin
    if (rst || FlushE) begin
      m_rd1 = 0; m_rd2 = 0; m_pc = 0; m_imm = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0;
      m_sa = 0; m_sb = 0; m_rw = 0; m_mw = 0; m_rsrc = 0;
    end else if (!StallE) begin
      m_rd1 = RD1D; m_rd2 = RD2D; m_pc = PCD; m_imm = ImmExtD;
      m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD; m_op = alu_opD;
      m_sa = ALUSrcAD; m_sb = ALUSrcBD; m_rw = RegWriteD; m_mw = MemWriteD;
      m_rsrc = ResultSrcD;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which older stage, if any, currently owns the newest value of register r.
  function automatic logic [1:0] src_of(input logic [4:0] r);
    if (r == 0) return 2'd0;
    if (RegWriteM && RdM == r) return 2'd2;
    if (RegWriteW && RdW == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] value_of(input logic [4:0] r, input logic [31:0] rf);
    case (src_of(r))
      2'd2:    return ALUResultM;
      2'd1:    return ResultW;
      default: return rf;
    endcase
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      logic [31:0] a, b;
      a = value_of(m_rs1, m_rd1);
      b = value_of(m_rs2, m_rd2);
      chk("alu_opE",    32'(alu_opE),    32'(m_op));
      chk("PCE",        PCE,             m_pc);
      chk("RdE",        32'(RdE),        32'(m_rd));
      chk("RegWriteE",  32'(RegWriteE),  32'(m_rw));
      chk("MemWriteE",  32'(MemWriteE),  32'(m_mw));
      chk("ResultSrcE", 32'(ResultSrcE), 32'(m_rsrc));
      chk("ForwardAE",  32'(ForwardAE),  32'(src_of(m_rs1)));
      chk("ForwardBE",  32'(ForwardBE),  32'(src_of(m_rs2)));
      chk("SrcAE",      SrcAE,           m_sa ? m_pc : a);
      chk("SrcBE",      SrcBE,           m_sb ? m_imm : b);
      chk("WriteDataE", WriteDataE,      b);
      chk("lwStall",    32'(lwStall),
          32'(m_rsrc == 2'b01 && m_rd != 0 && (m_rd == Rs1D || m_rd == Rs2D)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    StallE = 0; FlushE = 0;
    RD1D = 0; RD2D = 0; PCD = 0; ImmExtD = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0; alu_opD = 0;
    ALUSrcAD = 0; ALUSrcBD = 0; RegWriteD = 0; MemWriteD = 0; ResultSrcD = 0;
    ALUResultM = 0; RdM = 0; RegWriteM = 0;
    ResultW = 0; RdW = 0; RegWriteW = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    step();
    check_en = 1;
    rst = 0;

    // Reset produces a bubble even over a loaded instruction.
    RD1D = 5; RD2D = 7; alu_opD = 5'b00001; RegWriteD = 1; RdD = 3;
    step();
    chk("loaded_RdE", 32'(RdE), 32'd3);
    chk("loaded_SrcAE", SrcAE, 32'd5);
    rst = 1;
    step();
    rst = 0;
    chk("rst_alu_opE", 32'(alu_opE), 32'd0);
    chk("rst_RegWriteE", 32'(RegWriteE), 32'd0);
    chk("rst_RdE", 32'(RdE), 32'd0);
    chk("rst_SrcAE", SrcAE, 32'd0);
    chk("rst_SrcBE", SrcBE, 32'd0);
    chk("rst_WriteDataE", WriteDataE, 32'd0);
    chk("rst_lwStall", 32'(lwStall), 32'd0);

    // Memory beats Writeback; dropping M falls back to W.
    clear_inputs();
    Rs1D = 4; RD1D = 32'h55;
    step();
    RdM = 4; RegWriteM = 1; ALUResultM = 32'h10;
    RdW = 4; RegWriteW = 1; ResultW = 32'h20;
    #1;
    chk("prio_ForwardAE_M", 32'(ForwardAE), 32'd2);
    chk("prio_SrcAE_M", SrcAE, 32'h10);
    RegWriteM = 0;
    #1;
    chk("prio_ForwardAE_W", 32'(ForwardAE), 32'd1);
    chk("prio_SrcAE_W", SrcAE, 32'h20);
    RegWriteW = 0;
    #1;
    chk("prio_SrcAE_rf", SrcAE, 32'h55);

    // x0 is never forwarded.
    clear_inputs();
    step();
    RdM = 0; RegWriteM = 1; ALUResultM = 32'hFF;
    #1;
    chk("x0_ForwardBE", 32'(ForwardBE), 32'd0);
    chk("x0_WriteDataE", WriteDataE, 32'd0);

    // PC/immediate selection; store data still forwarded.
    clear_inputs();
    ALUSrcAD = 1; PCD = 32'h100; ALUSrcBD = 1; ImmExtD = 32'h8;
    Rs2D = 9; RD2D = 32'h33;
    step();
    RdM = 9; RegWriteM = 1; ALUResultM = 32'hABC;
    #1;
    chk("sel_SrcAE", SrcAE, 32'h100);
    chk("sel_SrcBE", SrcBE, 32'h8);
    chk("sel_ForwardBE", 32'(ForwardBE), 32'd2);
    chk("sel_WriteDataE", WriteDataE, 32'hABC);

    // Stall holds, stall+flush bubbles.
    clear_inputs();
    RD1D = 32'h11; Rs1D = 1; alu_opD = 3; RdD = 5; RegWriteD = 1;
    MemWriteD = 1; PCD = 32'h40;
    step();
    StallE = 1;
    RD1D = 32'h99; RdD = 7; alu_opD = 9; PCD = 32'h80; MemWriteD = 0;
    step();
    step();
    chk("stall_SrcAE", SrcAE, 32'h11);
    chk("stall_RdE", 32'(RdE), 32'd5);
    chk("stall_alu_opE", 32'(alu_opE), 32'd3);
    chk("stall_PCE", PCE, 32'h40);
    chk("stall_MemWriteE", 32'(MemWriteE), 32'd1);
    FlushE = 1;
    step();
    chk("flush_SrcAE", SrcAE, 32'd0);
    chk("flush_RdE", 32'(RdE), 32'd0);
    chk("flush_PCE", PCE, 32'd0);
    chk("flush_RegWriteE", 32'(RegWriteE), 32'd0);

    // Load-use detection and its x0 guard.
    clear_inputs();
    ResultSrcD = 2'b01; RdD = 6; RegWriteD = 1;
    step();
    Rs2D = 6;
    #1;
    chk("lu_hit", 32'(lwStall), 32'd1);
    Rs2D = 2; Rs1D = 6;
    #1;
    chk("lu_hit_rs1", 32'(lwStall), 32'd1);
    ResultSrcD = 2'b01; RdD = 0; Rs1D = 0; Rs2D = 0;
    step();
    chk("lu_x0", 32'(lwStall), 32'd0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      FlushE     = ($urandom_range(0, 99) < 10);
      StallE     = ($urandom_range(0, 99) < 25);
      RD1D       = $urandom; RD2D = $urandom; PCD = $urandom; ImmExtD = $urandom;
      Rs1D       = 5'($urandom_range(0, 7));
      Rs2D       = 5'($urandom_range(0, 7));
      RdD        = 5'($urandom_range(0, 7));
      alu_opD    = 5'($urandom);
      ALUSrcAD   = 1'($urandom); ALUSrcBD = 1'($urandom);
      RegWriteD  = 1'($urandom); MemWriteD = 1'($urandom);
      ResultSrcD = 2'($urandom);
      ALUResultM = $urandom; RdM = 5'($urandom_range(0, 7)); RegWriteM = 1'($urandom);
      ResultW    = $urandom; RdW = 5'($urandom_range(0, 7)); RegWriteW = 1'($urandom);
      step();
    end

    check_en = 0;
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
